// File: rtl/tlb_maint.sv
// tlb_maint: maintenance side of the TLB (TLBP, TLBR, TLBWI, TLBWR) and owner
// of the CP0 Random counter. Drives the array's write port and its single
// combinational read port.
// Build option: define TLB_PROBE_MULTIHIT_EN to make TLBP scan every entry,
// report the lowest matching index and flag multiple hits on output multihit.
module tlb_maint #(
    parameter int unsigned NUM_TLB_ENTRY = 16,
    parameter int unsigned IDX_W         = $clog2(NUM_TLB_ENTRY),
    parameter int unsigned ENTRY_W       = 78
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [1:0]         op_code,
    output logic               op_ready,
    input  logic [IDX_W-1:0]   cp0_index,
    input  logic [IDX_W-1:0]   cp0_wired,
    input  logic               wired_we,
    input  logic [31:0]        cp0_entryhi,
    input  logic [31:0]        cp0_entrylo0,
    input  logic [31:0]        cp0_entrylo1,
    output logic [IDX_W-1:0]   cp0_random,
    output logic               done,
    output logic               probe_miss,
    output logic [IDX_W-1:0]   probe_index,
    output logic [31:0]        rd_entryhi,
    output logic [31:0]        rd_entrylo0,
    output logic [31:0]        rd_entrylo1,
    output logic [IDX_W-1:0]   tlb_raddr,
    input  logic [ENTRY_W-1:0] tlb_rdata,
    output logic               tlb_we,
    output logic [IDX_W-1:0]   tlb_waddr,
    output logic [ENTRY_W-1:0] tlb_wdata
`ifdef TLB_PROBE_MULTIHIT_EN
    ,
    output logic               multihit
`endif
);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_PROBE = 2'd2
    } state_e;

    localparam logic [1:0]       OP_TLBP  = 2'b00;
    localparam logic [1:0]       OP_TLBR  = 2'b01;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TLB_ENTRY - 1);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [18:0]      vpn2_q, vpn2_d;
    logic [7:0]       asid_q, asid_d;
    logic [IDX_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0] random_q, random_d;
    logic             done_q, done_d;
    logic             tlb_we_q, tlb_we_d;
    logic [IDX_W-1:0] tlb_waddr_q, tlb_waddr_d;
    tlb_entry_t       tlb_wdata_q, tlb_wdata_d;
    logic             probe_miss_q, probe_miss_d;
    logic [IDX_W-1:0] probe_index_q, probe_index_d;
    logic [31:0]      rd_entryhi_q, rd_entryhi_d;
    logic [31:0]      rd_entrylo0_q, rd_entrylo0_d;
    logic [31:0]      rd_entrylo1_q, rd_entrylo1_d;
`ifdef TLB_PROBE_MULTIHIT_EN
    logic             found_q, found_d;
    logic [IDX_W-1:0] first_q, first_d;
    logic             multi_q, multi_d;
    logic             multihit_q, multihit_d;
`endif

    tlb_entry_t rd_ent;
    tlb_entry_t wr_ent;
    logic       accept;
    logic       match;
    logic       unused_bits;

    assign rd_ent      = tlb_entry_t'(tlb_rdata);
    assign accept      = op_valid && (state_q == S_IDLE);
    assign match       = (rd_ent.vpn2 == vpn2_q) && (rd_ent.g || (rd_ent.asid == asid_q));
    assign unused_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

    // Entry image built straight from the CP0 registers for a write.
    always_comb begin
        wr_ent      = '0;
        wr_ent.vpn2 = cp0_entryhi[31:13];
        wr_ent.asid = cp0_entryhi[7:0];
        wr_ent.g    = cp0_entrylo0[0] & cp0_entrylo1[0];
        wr_ent.pfn0 = cp0_entrylo0[25:6];
        wr_ent.c0   = cp0_entrylo0[5:3];
        wr_ent.d0   = cp0_entrylo0[2];
        wr_ent.v0   = cp0_entrylo0[1];
        wr_ent.pfn1 = cp0_entrylo1[25:6];
        wr_ent.c1   = cp0_entrylo1[5:3];
        wr_ent.d1   = cp0_entrylo1[2];
        wr_ent.v1   = cp0_entrylo1[1];
    end

    // Read-port address and handshake, combinational from state.
    always_comb begin
        op_ready  = (state_q == S_IDLE);
        tlb_raddr = '0;
        if (state_q == S_EXEC && op_q == OP_TLBR) begin
            tlb_raddr = index_q;
        end else if (state_q == S_PROBE) begin
            tlb_raddr = scan_q;
        end
    end

    // Random counter: free-running down-count, wrapping at or below Wired.
    always_comb begin
        random_d = IDX_W'(random_q - 1'b1);
        if (wired_we || (random_q == cp0_wired) || (cp0_wired > random_q)) begin
            random_d = LAST_IDX;
        end
    end

    // Next-state and registered-output logic of the operation sequencer.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        index_d       = index_q;
        vpn2_d        = vpn2_q;
        asid_d        = asid_q;
        scan_d        = scan_q;
        done_d        = 1'b0;
        tlb_we_d      = 1'b0;
        tlb_waddr_d   = tlb_waddr_q;
        tlb_wdata_d   = tlb_wdata_q;
        probe_miss_d  = probe_miss_q;
        probe_index_d = probe_index_q;
        rd_entryhi_d  = rd_entryhi_q;
        rd_entrylo0_d = rd_entrylo0_q;
        rd_entrylo1_d = rd_entrylo1_q;
`ifdef TLB_PROBE_MULTIHIT_EN
        found_d       = found_q;
        first_d       = first_q;
        multi_d       = multi_q;
        multihit_d    = multihit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op_code;
                    index_d = cp0_index;
                    vpn2_d  = cp0_entryhi[31:13];
                    asid_d  = cp0_entryhi[7:0];
                    scan_d  = '0;
`ifdef TLB_PROBE_MULTIHIT_EN
                    found_d = 1'b0;
                    multi_d = 1'b0;
`endif
                    state_d = (op_code == OP_TLBP) ? S_PROBE : S_EXEC;
                    // Writes go out on the first busy cycle; TLBWR takes the pre-update Random.
                    if (op_code[1]) begin
                        tlb_we_d    = 1'b1;
                        tlb_waddr_d = op_code[0] ? random_q : cp0_index;
                        tlb_wdata_d = wr_ent;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q == OP_TLBR) begin
                    rd_entryhi_d  = {rd_ent.vpn2, 5'b0, rd_ent.asid};
                    rd_entrylo0_d = {6'b0, rd_ent.pfn0, rd_ent.c0, rd_ent.d0, rd_ent.v0, rd_ent.g};
                    rd_entrylo1_d = {6'b0, rd_ent.pfn1, rd_ent.c1, rd_ent.d1, rd_ent.v1, rd_ent.g};
                end
            end
            S_PROBE: begin
                scan_d = IDX_W'(scan_q + 1'b1);
`ifdef TLB_PROBE_MULTIHIT_EN
                if (match) begin
                    if (!found_q) begin
                        found_d = 1'b1;
                        first_d = scan_q;
                    end else begin
                        multi_d = 1'b1;
                    end
                end
                if (scan_q == LAST_IDX) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    multihit_d = multi_q | (match & found_q);
                    if (found_q || match) begin
                        probe_miss_d  = 1'b0;
                        probe_index_d = found_q ? first_q : scan_q;
                    end else begin
                        probe_miss_d  = 1'b1;
                    end
                end
`else
                if (match) begin
                    state_d       = S_IDLE;
                    done_d        = 1'b1;
                    probe_miss_d  = 1'b0;
                    probe_index_d = scan_q;
                end else if (scan_q == LAST_IDX) begin
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                    probe_miss_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            index_q       <= '0;
            vpn2_q        <= '0;
            asid_q        <= '0;
            scan_q        <= '0;
            random_q      <= LAST_IDX;
            done_q        <= 1'b0;
            tlb_we_q      <= 1'b0;
            tlb_waddr_q   <= '0;
            tlb_wdata_q   <= '0;
            probe_miss_q  <= 1'b0;
            probe_index_q <= '0;
            rd_entryhi_q  <= '0;
            rd_entrylo0_q <= '0;
            rd_entrylo1_q <= '0;
`ifdef TLB_PROBE_MULTIHIT_EN
            found_q       <= 1'b0;
            first_q       <= '0;
            multi_q       <= 1'b0;
            multihit_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            index_q       <= index_d;
            vpn2_q        <= vpn2_d;
            asid_q        <= asid_d;
            scan_q        <= scan_d;
            random_q      <= random_d;
            done_q        <= done_d;
            tlb_we_q      <= tlb_we_d;
            tlb_waddr_q   <= tlb_waddr_d;
            tlb_wdata_q   <= tlb_wdata_d;
            probe_miss_q  <= probe_miss_d;
            probe_index_q <= probe_index_d;
            rd_entryhi_q  <= rd_entryhi_d;
            rd_entrylo0_q <= rd_entrylo0_d;
            rd_entrylo1_q <= rd_entrylo1_d;
`ifdef TLB_PROBE_MULTIHIT_EN
            found_q       <= found_d;
            first_q       <= first_d;
            multi_q       <= multi_d;
            multihit_q    <= multihit_d;
`endif
        end
    end

    assign cp0_random  = random_q;
    assign done        = done_q;
    assign tlb_we      = tlb_we_q;
    assign tlb_waddr   = tlb_waddr_q;
    assign tlb_wdata   = ENTRY_W'(tlb_wdata_q);
    assign probe_miss  = probe_miss_q;
    assign probe_index = probe_index_q;
    assign rd_entryhi  = rd_entryhi_q;
    assign rd_entrylo0 = rd_entrylo0_q;
    assign rd_entrylo1 = rd_entrylo1_q;
`ifdef TLB_PROBE_MULTIHIT_EN
    assign multihit    = multihit_q;
`endif

endmodule

// File: doc/tlb_maint.md
Name: tlb_maint

Overview:
- Write/maintenance side of the TLB. The translation datapath only looks entries up; this block fills and inspects them.
- Executes CP0 TLB instructions: TLBP (probe), TLBR (read), TLBWI (write indexed) and TLBWR (write random).
- Owns the CP0 Random counter and drives the TLB array's single write port and single combinational read port.
- Sits between the CP0/exception stage and the tlb array. The pipeline stalls while op_ready is low.

Parameters:
- NUM_TLB_ENTRY, 16, number of TLB entries; power of two, minimum 2.
- IDX_W, $clog2(NUM_TLB_ENTRY), width of the index fields.
- ENTRY_W, 78, packed entry width: {vpn2[18:0], asid[7:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1}.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  request a TLB operation.
- op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
- op_ready  out  1  high in IDLE only; an operation is accepted when op_valid & op_ready.
- cp0_index  in  IDX_W  Index register value.
- cp0_wired  in  IDX_W  Wired register value.
- wired_we  in  1  Wired is being written this cycle.
- cp0_entryhi  in  32  EntryHi: vpn2 in [31:13], asid in [7:0].
- cp0_entrylo0  in  32  EntryLo0: pfn in [25:6], c in [5:3], d [2], v [1], g [0].
- cp0_entrylo1  in  32  EntryLo1, same layout as EntryLo0.
- cp0_random  out  IDX_W  current Random register value.
- done  out  1  one-cycle pulse when the operation completes.
- probe_miss  out  1  TLBP result: no entry matched (becomes Index.P).
- probe_index  out  IDX_W  TLBP result: index of the matching entry.
- rd_entryhi  out  32  TLBR result.
- rd_entrylo0  out  32  TLBR result.
- rd_entrylo1  out  32  TLBR result.
- tlb_raddr  out  IDX_W  TLB read-port address.
- tlb_rdata  in  ENTRY_W  TLB read data, combinational from tlb_raddr.
- tlb_we  out  1  TLB write enable.
- tlb_waddr  out  IDX_W  TLB write address.
- tlb_wdata  out  ENTRY_W  TLB write data.

Behaviour:
- Reset values:
  - state IDLE.
  - cp0_random = NUM_TLB_ENTRY-1.
  - done, tlb_we, probe_miss = 0.
  - probe_index, rd_* = 0.
  - tlb_raddr, tlb_waddr, tlb_wdata = 0.
- States: IDLE, EXEC, PROBE. All outputs other than op_ready and tlb_raddr are registered.
- On accept (edge k), the block latches op_code, entryhi, entrylo0/1 and cp0_index. For TLBWR it also latches the current cp0_random.
- IDLE -> EXEC for TLBR, TLBWI and TLBWR. IDLE -> PROBE for TLBP.
- EXEC (cycle k+1):
  - TLBR: tlb_raddr = latched index. rd_* are formatted from tlb_rdata; both EntryLo g bits = entry g.
  - TLBWI/TLBWR: tlb_we = 1 for exactly this cycle, tlb_waddr = latched index or latched random. Entry g = entrylo0.g & entrylo1.g.
  - EXEC -> IDLE; done pulses in cycle k+2.
- PROBE:
  - A scan counter starts at 0 and drives tlb_raddr, one entry per cycle.
  - Match condition: vpn2 equal AND (entry g OR entry asid == latched asid).
  - On the first match at entry i: probe_index = i, probe_miss = 0, go to IDLE. done pulses at cycle k+i+2.
  - If no entry matches after entry NUM_TLB_ENTRY-1: probe_miss = 1, probe_index unchanged, go to IDLE. done pulses at cycle k+NUM_TLB_ENTRY+1.
- Results hold their value until the next done of the same operation type.
- Index out of range cannot occur, because widths are exact.
- Random counter, evaluated every cycle regardless of state:
  - If wired_we: random <= NUM-1.
  - Else if random == wired or wired > random: random <= NUM-1.
  - Else: random <= random-1.
  - If wired == NUM-1, random stays at NUM-1.
- Simultaneous events:
  - wired_we in the same cycle as a TLBWR accept: TLBWR uses the pre-update random.
  - op_valid while busy is ignored. The requester must hold op_valid until op_ready.
- Reset mid-operation: the operation is abandoned, no further tlb_we, no done. Entries already written are not restored.

Optional Feature:
- Macro: TLB_PROBE_MULTIHIT_EN.
- When defined:
  - PROBE always scans all NUM_TLB_ENTRY entries; TLBP done always pulses at cycle k+NUM+1.
  - probe_index = the lowest matching index.
  - Adds output multihit (1 bit), registered with done, set when two or more entries match. Reset value 0.
- When undefined: early exit on the first hit, and the multihit port is absent.

Test Plan:
- After reset, with wired=0 and NUM=16, idle for 20 cycles: cp0_random sequence is 15,14,...,0,15,14,13,12.
- wired=4, random=5: the next values are 4 then 15. Pulse wired_we while random=9: random = 15 next cycle.
- TLBWI with index=3, entryhi=0x00402005, lo0=0x00000017, lo1=0x00000047: single tlb_we at k+1 with waddr=3, g=1. done at k+2.
- Then TLBR with index=3: rd_entryhi=0x00402005, rd_entrylo0=0x00000017, rd_entrylo1=0x00000047, done at k+2.
- TLBP with entryhi=0x00402099 against that entry: hit through g, probe_index=3, probe_miss=0, done at k+5. Clear g in the entry and repeat with asid 0x99: probe_miss=1, done at k+17.
- Assert rst during PROBE: state IDLE, no done, op_ready=1 the cycle after reset. With TLB_PROBE_MULTIHIT_EN defined, duplicate the entry at 3 and 9 and probe: index=3, multihit=1, done at k+17.
